// File: rtl/dpram_rd_streamer_pkg.sv
// Shared definitions for the dual-port RAM read streamer: FSM encoding and
// the default skid-FIFO capacity for a given RAM read latency.
package dpram_rd_streamer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
  localparam logic [2:0] S_ZERO  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_FIN   = S_FIN,
    ST_ZERO  = S_ZERO
  } state_t;

  // Every in-flight RAM read plus one head word and one landing slot.
  function automatic int cap_default(input int n_delay);
    return n_delay + 2;
  endfunction

endpackage

// File: rtl/dpram_rd_streamer_rd_skid_fifo.sv
// Synchronous skid FIFO with a registered head word; the head is refilled from
// the body storage or, when the body is empty, directly from the push port.
module rd_skid_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [W-1:0]                 head_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BD = DEPTH - 1;
  localparam int PW = (BD > 1) ? $clog2(BD) : 1;

  logic [W-1:0]  body [BD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] body_count;
  logic          head_load;
  logic          from_body;
  logic          direct;
  logic          body_push;
  logic          body_pop;

  always_comb begin
    head_load = !head_valid || (pop && head_valid);
    from_body = head_load && (body_count != '0);
    direct    = head_load && (body_count == '0) && push;
    body_push = push && !direct;
    body_pop  = from_body;
  end

  assign count = body_count + CW'(head_valid);

  always_ff @(posedge clk) begin
    if (body_push) begin
      body[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      body_count <= '0;
    end else begin
      if (body_push) begin
        wr_ptr <= (wr_ptr == PW'(BD - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (body_pop) begin
        rd_ptr <= (rd_ptr == PW'(BD - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({body_push, body_pop})
        2'b10:   body_count <= body_count + 1'b1;
        2'b01:   body_count <= body_count - 1'b1;
        default: body_count <= body_count;
      endcase
    end
  end

  // Head keeps its data when it empties so the stream output stays quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (head_load) begin
      if (from_body) begin
        head_valid <= 1'b1;
        head_data  <= body[rd_ptr];
      end else if (push) begin
        head_valid <= 1'b1;
        head_data  <= push_data;
      end else begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dpram_rd_streamer.sv
// Burst read controller for the dual-port RAM: issues enb/addrb under a credit
// limit, realigns the fixed read latency and streams words via a skid FIFO.
module dpram_rd_streamer
  import dpram_rd_streamer_pkg::*;
#(
  parameter int DW      = 64,
  parameter int AW      = 8,
  parameter int DEPTH   = 256,
  parameter int N_DELAY = 1,
  parameter int CAP     = cap_default(N_DELAY)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int CW = $clog2(CAP + 1);
  localparam logic [CW:0] CAP_L = (CW + 1)'(CAP);

  state_t              state;
  state_t              state_nxt;
  logic [AW:0]         num_q;
  logic [AW:0]         issued;
  logic [N_DELAY-1:0]  pipe_valid;
  logic [N_DELAY-1:0]  pipe_last;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       inflight;
  logic [CW:0]         occupancy;
  logic                issue;
  logic                pop;
  logic                last_tag;
  logic [DW:0]         head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      inflight = inflight + CW'(pipe_valid[i]);
    end
  end

  // Credit check uses this cycle's pop so a draining stream never stalls reads.
  assign pop       = m_valid && m_ready;
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign last_tag  = (issued == num_q - 1'b1);
  assign issue     = (state == ST_RUN) && (issued < num_q) && (occupancy < CAP_L);
  assign enb       = issue;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (num_words != '0) ? ST_RUN : ST_ZERO;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (issue && last_tag) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && m_last) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ZERO: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q  <= '0;
      issued <= '0;
      addrb  <= '0;
    end else if (state == ST_IDLE && start) begin
      num_q  <= num_words;
      issued <= '0;
      addrb  <= start_addr;
    end else if (issue) begin
      issued <= issued + 1'b1;
      addrb  <= (addrb == AW'(DEPTH - 1)) ? '0 : addrb + 1'b1;
    end
  end

  // Tags travel alongside the RAM read so dob is captured exactly when valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue && last_tag;
      for (int i = 1; i < N_DELAY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  rd_skid_fifo #(
    .W     (DW + 1),
    .DEPTH (CAP)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (pipe_valid[N_DELAY-1]),
    .push_data  ({pipe_last[N_DELAY-1], dob}),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (m_valid),
    .head_data  (head)
  );

  assign m_data = head[DW-1:0];
  assign m_last = m_valid && head[DW];

endmodule
